// File: rtl/mux_skid_n.sv
// rtl/mux_skid_n.sv - N-input registered data selector behind a 2-entry skid buffer.
// Defining MUX_SKID_ERRCNT_EN adds the sel_err pulse and saturating err_count outputs.
module mux_skid_n #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_SKID_ERRCNT_EN
    ,
    output logic               sel_err,
    output logic [7:0]         err_count
`endif
);

    localparam logic [SELW:0] N_L = (SELW+1)'(N);

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_last_sel;

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_beat;
    logic             w_sel_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_consume;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                w_sel_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    // An out-of-range select repeats whatever was last validly selected.
    assign w_sel_ok   = {1'b0, sel} < N_L;
    assign w_beat     = w_sel_ok ? w_sel_data : r_last_sel;
    assign w_in_ready = !r_skid_valid && !flush && reset_n;
    assign w_accept   = in_valid && w_in_ready;
    assign w_consume  = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_last_sel   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_accept && w_sel_ok) begin
                r_last_sel <= w_sel_data;
            end
            if (w_consume) begin
                // A full skid blocks acceptance, so these two cases never collide.
                if (r_skid_valid) begin
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main_data  <= w_beat;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_main_valid) begin
                    r_main_data  <= w_beat;
                    r_main_valid <= 1'b1;
                end else begin
                    r_skid_data  <= w_beat;
                    r_skid_valid <= 1'b1;
                end
            end
        end
    end

`ifdef MUX_SKID_ERRCNT_EN
    logic       r_sel_err;
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sel_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_sel_err <= w_accept && !w_sel_ok;
            if (w_accept && !w_sel_ok && r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign sel_err   = r_sel_err;
    assign err_count = r_err_count;
`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_main_data;
    assign out_valid = r_main_valid;

endmodule
